// File: rtl/key_sched_ctrl_if.sv
// Handshake bundle between the key-schedule sequencer and the shared GenSubKey
// instance; master is the sequencer side, slave is GenSubKey.
interface key_sched_ctrl_if #(
  parameter int KEY_LEN  = 128,
  parameter int WORD_LEN = 32
);
  logic                sub_valid_in;
  logic [KEY_LEN-1:0]  sub_data_in;
  logic [WORD_LEN-1:0] sub_rcon;
  logic                sub_valid_out;
  logic [KEY_LEN-1:0]  sub_data_out;

  modport master (
    output sub_valid_in,
    output sub_data_in,
    output sub_rcon,
    input  sub_valid_out,
    input  sub_data_out
  );

  modport slave (
    input  sub_valid_in,
    input  sub_data_in,
    input  sub_rcon,
    output sub_valid_out,
    output sub_data_out
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// AES-128 key expansion sequencer: steps one external GenSubKey through rounds
// 1..10 with the matching Rcon and keeps all 11 round keys in a readable bank.
module key_sched_ctrl #(
  parameter int KEY_LEN    = 128,
  parameter int WORD_LEN   = 32,
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_LEN-1:0] key_in,
  output logic               busy,
  output logic               done,
  output logic               keys_valid,
  output logic               error,
  input  logic [3:0]         rd_addr,
  output logic [KEY_LEN-1:0] rd_key,
  key_sched_ctrl_if.master   sub
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state;
  logic [3:0]         round;
  logic [7:0]         rc;
  logic [CNT_W-1:0]   wait_cnt;
  logic [KEY_LEN-1:0] prev_key;
  logic [KEY_LEN-1:0] bank [0:NUM_ROUNDS];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // The previous round key and current Rcon are already registered, so they
  // feed GenSubKey directly and are stable across the whole issue cycle.
  assign sub.sub_data_in = prev_key;
  assign sub.sub_rcon    = {rc, {(WORD_LEN-8){1'b0}}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      round            <= '0;
      rc               <= '0;
      wait_cnt         <= '0;
      prev_key         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      keys_valid       <= 1'b0;
      error            <= 1'b0;
      sub.sub_valid_in <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) bank[i] <= '0;
    end else begin
      done             <= 1'b0;
      sub.sub_valid_in <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bank[0]          <= key_in;
            prev_key         <= key_in;
            round            <= 4'd1;
            rc               <= 8'h01;
            keys_valid       <= 1'b0;
            error            <= 1'b0;
            busy             <= 1'b1;
            sub.sub_valid_in <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (sub.sub_valid_out) begin
            bank[round] <= sub.sub_data_out;
            prev_key    <= sub.sub_data_out;
            if (round == 4'(NUM_ROUNDS)) begin
              done       <= 1'b1;
              keys_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              round            <= round + 4'd1;
              rc               <= xtime(rc);
              sub.sub_valid_in <= 1'b1;
              state            <= ISSUE;
            end
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // A stalled GenSubKey abandons the run; keys_valid stays low.
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads see the bank before any same-edge write; unused addresses read zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_key <= '0;
    end else if (rd_addr <= 4'(NUM_ROUNDS)) begin
      rd_key <= bank[rd_addr];
    end else begin
      rd_key <= '0;
    end
  end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: a behavioural GenSubKey with 4-cycle latency,
// issue/read scoreboards and table-driven read sweeps.
module tb_key_sched_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] exp;
    string        name;
  } rd_vec_t;

  typedef struct {
    logic [7:0]   rc;
    logic [127:0] data;
  } iss_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         error;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
  logic         stall;

  int tests_run    = 0;
  int tests_failed = 0;
  logic prev_svi   = 1'b0;

  rd_vec_t rd_q[$];
  iss_t    iss_q[$];
  rd_vec_t vecs [0:15];

  key_sched_ctrl_if #(.KEY_LEN(128), .WORD_LEN(32)) sub_if ();

  key_sched_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .error      (error),
    .rd_addr    (rd_addr),
    .rd_key     (rd_key),
    .sub        (sub_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // GenSubKey stand-in: output valid in the 4th cycle after the sampling edge.
  logic [3:0]   model_v;
  logic [127:0] model_d [0:3];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_v <= 4'h0;
      for (int i = 0; i < 4; i++) model_d[i] <= 128'h0;
    end else begin
      model_v    <= {model_v[2:0], sub_if.sub_valid_in};
      model_d[0] <= sub_if.sub_valid_in ?
                    next_round_key(sub_if.sub_data_in, sub_if.sub_rcon[31:24]) : 128'h0;
      model_d[1] <= model_d[0];
      model_d[2] <= model_d[1];
      model_d[3] <= model_d[2];
    end
  end
  assign sub_if.sub_valid_out = model_v[3] & ~stall;
  assign sub_if.sub_data_out  = model_d[3];

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input rd_vec_t v);
    rd_addr = v.addr;
    rd_q.push_back(v);
  endtask

  task automatic step_cycle();
    rd_vec_t r;
    iss_t    s;
    @(posedge clk);
    #1;
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      checkOutput(r.name, rd_key, r.exp);
    end
    if (sub_if.sub_valid_in === 1'b1) begin
      checkOutput("svi_single_cycle", 128'(prev_svi), 128'(0));
      if (iss_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL svi_unexpected: got sub_valid_in=1, expected no issue");
      end else begin
        s = iss_q.pop_front();
        checkOutput("issue_rcon", 128'(sub_if.sub_rcon), 128'({s.rc, 24'h0}));
        checkOutput("issue_data", sub_if.sub_data_in, s.data);
      end
    end
    prev_svi = sub_if.sub_valid_in;
  endtask

  task automatic start_run(input logic [127:0] key);
    logic [127:0] k;
    k = key;
    for (int r = 0; r < 10; r++) begin
      iss_q.push_back('{RCON[r], k});
      k = next_round_key(k, RCON[r]);
    end
    start  = 1'b1;
    key_in = key;
    step_cycle();
    start  = 1'b0;
  endtask

  // Steps until done, optionally pulsing a stray start sampled at edge pulse_at.
  task automatic wait_done(input int bound, input int pulse_at, output int first);
    first = -1;
    for (int k = 1; k <= bound; k++) begin
      step_cycle();
      if (k == pulse_at) start = 1'b0;
      if (done === 1'b1) begin
        first = k;
        break;
      end
      if (k == pulse_at - 1) begin
        start  = 1'b1;
        key_in = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      end
    end
  endtask

  initial begin
    int first_k;
    logic [127:0] kk;

    reset = 1'b0; start = 1'b0; key_in = '0; rd_addr = '0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",       128'(busy),                128'(0));
    checkOutput("reset_done",       128'(done),                128'(0));
    checkOutput("reset_keys_valid", 128'(keys_valid),          128'(0));
    checkOutput("reset_error",      128'(error),               128'(0));
    checkOutput("reset_rd_key",     rd_key,                    128'(0));
    checkOutput("reset_svi",        128'(sub_if.sub_valid_in), 128'(0));
    checkOutput("reset_sub_data",   sub_if.sub_data_in,        128'(0));
    checkOutput("reset_sub_rcon",   128'(sub_if.sub_rcon),     128'(0));
    reset = 1'b1;
    step_cycle();

    start_run(FIPS_KEY);
    checkOutput("fips_busy_high", 128'(busy), 128'(1));
    wait_done(80, 20, first_k);
    checkOutput("fips_done_edge",   128'(first_k),      128'(50));
    checkOutput("fips_keys_valid",  128'(keys_valid),   128'(1));
    checkOutput("fips_busy_low",    128'(busy),         128'(0));
    checkOutput("fips_all_issued",  128'(iss_q.size()), 128'(0));

    start_run(FIPS_KEY);
    checkOutput("restart_keys_valid_cleared", 128'(keys_valid), 128'(0));
    checkOutput("restart_busy",               128'(busy),       128'(1));
    checkOutput("restart_done_low",           128'(done),       128'(0));
    wait_done(80, -1, first_k);
    checkOutput("restart_done_edge", 128'(first_k), 128'(50));
    step_cycle();
    checkOutput("done_single_pulse", 128'(done),       128'(0));
    checkOutput("keys_valid_level",  128'(keys_valid), 128'(1));

    kk = FIPS_KEY;
    for (int i = 0; i < 16; i++) begin
      vecs[i].addr = 4'(i);
      vecs[i].exp  = (i <= 10) ? kk : 128'h0;
      vecs[i].name = $sformatf("sweep_addr%0d", i);
      if (i < 10) kk = next_round_key(kk, RCON[i]);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      step_cycle();
    end
    applyStimulus('{4'd1, FIPS_R1, "fips_slot1"});
    step_cycle();
    applyStimulus('{4'd10, FIPS_R10, "fips_slot10"});
    step_cycle();

    start_run(128'h0);
    wait_done(80, -1, first_k);
    checkOutput("zero_done_edge", 128'(first_k), 128'(50));
    applyStimulus('{4'd1, ZERO_R1, "zero_slot1"});
    step_cycle();
    applyStimulus('{4'd10, ZERO_R10, "zero_slot10"});
    step_cycle();

    start_run(FIPS_KEY);
    first_k = -1;
    for (int k = 1; k <= 40; k++) begin
      step_cycle();
      if (k == 11) stall = 1'b1;
      if (error === 1'b1) begin
        first_k = k;
        break;
      end
    end
    checkOutput("timeout_edge",       128'(first_k),    128'(26));
    checkOutput("timeout_busy_low",   128'(busy),       128'(0));
    checkOutput("timeout_keys_valid", 128'(keys_valid), 128'(0));
    stall = 1'b0;
    iss_q.delete();
    repeat (5) step_cycle();
    checkOutput("timeout_stays_idle", 128'(busy),  128'(0));
    checkOutput("error_sticky",       128'(error), 128'(1));

    start_run(ALT_KEY);
    checkOutput("start_clears_error", 128'(error), 128'(0));
    applyStimulus('{4'd0, ALT_KEY, "alt_slot0"});
    step_cycle();
    repeat (26) step_cycle();
    reset = 1'b0;
    #1;
    checkOutput("midreset_busy",       128'(busy),                128'(0));
    checkOutput("midreset_done",       128'(done),                128'(0));
    checkOutput("midreset_keys_valid", 128'(keys_valid),          128'(0));
    checkOutput("midreset_error",      128'(error),               128'(0));
    checkOutput("midreset_svi",        128'(sub_if.sub_valid_in), 128'(0));
    checkOutput("midreset_sub_data",   sub_if.sub_data_in,        128'(0));
    checkOutput("midreset_sub_rcon",   128'(sub_if.sub_rcon),     128'(0));
    checkOutput("midreset_rd_key",     rd_key,                    128'(0));
    iss_q.delete();
    prev_svi = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus('{4'd0, 128'h0, "post_reset_slot0"});
    step_cycle();
    repeat (10) step_cycle();
    checkOutput("post_reset_idle", 128'(busy), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
